latency_stats: RTL and testbench

LATENCY_STATS -- requirements
Module: latency_stats

---
 rtl/latency_stats.sv | 165 ++++++++++++++++
 tb/tb_latency_stats.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_stats.sv
// rtl/latency_stats.sv - one-stage stream register that gathers per-packet latency statistics
// The latency is sampled from the SOP beat's tuser; stats never backpressure the stream.
module latency_stats #(
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 48,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [LAT_WIDTH-1:0]  lat_thresh,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  input  logic [127:0]          i_tuser,
  output logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  output logic [127:0]          o_tuser,
  input  logic                  o_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  exceed_count,
  output logic [LAT_WIDTH-1:0]  lat_last,
  output logic [LAT_WIDTH-1:0]  lat_min,
  output logic [LAT_WIDTH-1:0]  lat_max,
  output logic [63:0]           lat_sum,
  output logic                  overflow
);

  typedef enum logic {ST_SOP = 1'b0, ST_BODY = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};

  state_t                state_q;
  logic [DATA_WIDTH-1:0] o_tdata_q;
  logic                  o_tlast_q;
  logic                  o_tvalid_q;
  logic [127:0]          o_tuser_q;

  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]  exceed_count_q, exceed_count_d;
  logic [LAT_WIDTH-1:0]  lat_last_q, lat_last_d;
  logic [LAT_WIDTH-1:0]  lat_min_q, lat_min_d;
  logic [LAT_WIDTH-1:0]  lat_max_q, lat_max_d;
  logic [63:0]           lat_sum_q, lat_sum_d;
  logic                  overflow_q, overflow_d;

  logic                  accept;
  logic                  sample;
  logic [LAT_WIDTH-1:0]  lat_s;

  logic [CNT_WIDTH-1:0]  cnt_b, exc_b;
  logic [LAT_WIDTH-1:0]  last_b, min_b, max_b;
  logic [63:0]           sum_b;
  logic                  ovf_b;
  logic [64:0]           sum_ext;

  assign i_tready = ~o_tvalid_q | o_tready;
  assign accept   = i_tvalid & i_tready;
  assign sample   = accept & (state_q == ST_SOP);
  assign lat_s    = i_tuser[LAT_WIDTH-1:0];

  assign o_tdata      = o_tdata_q;
  assign o_tlast      = o_tlast_q;
  assign o_tvalid     = o_tvalid_q;
  assign o_tuser      = o_tuser_q;
  assign pkt_count    = pkt_count_q;
  assign exceed_count = exceed_count_q;
  assign lat_last     = lat_last_q;
  assign lat_min      = lat_min_q;
  assign lat_max      = lat_max_q;
  assign lat_sum      = lat_sum_q;
  assign overflow     = overflow_q;

  // Output register and packet-position FSM share one block so both see the same accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SOP;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tuser_q  <= '0;
    end else begin
      if (accept) begin
        o_tdata_q  <= i_tdata;
        o_tlast_q  <= i_tlast;
        o_tuser_q  <= i_tuser;
        o_tvalid_q <= 1'b1;
        case (state_q)
          ST_SOP:  state_q <= i_tlast ? ST_SOP : ST_BODY;
          ST_BODY: state_q <= i_tlast ? ST_SOP : ST_BODY;
          default: state_q <= ST_SOP;
        endcase
      end else if (o_tready) begin
        o_tvalid_q <= 1'b0;
      end
    end
  end

  // A clear in the same cycle as a sample restarts stats with that sample as the first.
  always_comb begin
    cnt_b  = clear ? '0   : pkt_count_q;
    exc_b  = clear ? '0   : exceed_count_q;
    last_b = clear ? '0   : lat_last_q;
    min_b  = clear ? '1   : lat_min_q;
    max_b  = clear ? '0   : lat_max_q;
    sum_b  = clear ? '0   : lat_sum_q;
    ovf_b  = clear ? 1'b0 : overflow_q;

    pkt_count_d    = cnt_b;
    exceed_count_d = exc_b;
    lat_last_d     = last_b;
    lat_min_d      = min_b;
    lat_max_d      = max_b;
    lat_sum_d      = sum_b;
    overflow_d     = ovf_b;
    sum_ext        = {1'b0, sum_b} + {{(65-LAT_WIDTH){1'b0}}, lat_s};

    if (sample) begin
      lat_last_d = lat_s;
      if (cnt_b == CNT_ONES) begin
        overflow_d = 1'b1;
      end else begin
        pkt_count_d = cnt_b + CNT_WIDTH'(1);
      end
      if (lat_s > lat_thresh) begin
        if (exc_b == CNT_ONES) begin
          overflow_d = 1'b1;
        end else begin
          exceed_count_d = exc_b + CNT_WIDTH'(1);
        end
      end
      if (sum_ext[64]) begin
        lat_sum_d  = '1;
        overflow_d = 1'b1;
      end else begin
        lat_sum_d = sum_ext[63:0];
      end
      if ((cnt_b == '0) || (lat_s < min_b)) lat_min_d = lat_s;
      if ((cnt_b == '0) || (lat_s > max_b)) lat_max_d = lat_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q    <= '0;
      exceed_count_q <= '0;
      lat_last_q     <= '0;
      lat_min_q      <= '1;
      lat_max_q      <= '0;
      lat_sum_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      pkt_count_q    <= pkt_count_d;
      exceed_count_q <= exceed_count_d;
      lat_last_q     <= lat_last_d;
      lat_min_q      <= lat_min_d;
      lat_max_q      <= lat_max_d;
      lat_sum_q      <= lat_sum_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_latency_stats.sv
// tb/tb_latency_stats.sv - randomized and directed checks of latency_stats against a queue-based model
module tb_latency_stats;

  localparam int DW = 32;
  localparam int LW = 48;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam logic [LW-1:0] LONES = {LW{1'b1}};

  typedef struct packed {
    logic [127:0]  u;
    logic          l;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [LW-1:0] thr = '0;
  logic [DW-1:0] i_tdata = '0;
  logic          i_tlast = 1'b0;
  logic          i_tvalid = 1'b0;
  logic [127:0]  i_tuser = '0;
  logic          i_tready;
  logic [DW-1:0] o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic [127:0]  o_tuser;
  logic          o_tready = 1'b1;
  logic [CW-1:0] pkt_count, exceed_count;
  logic [LW-1:0] lat_last, lat_min, lat_max;
  logic [63:0]   lat_sum;
  logic          overflow;

  int n_checks = 0;
  int n_pass = 0;

  beat_t exp_q[$];
  logic  ready_q[$];
  int    rdy_mode = 0;
  logic  m_sop = 1'b1;
  logic [CW-1:0] m_cnt, m_exc;
  logic [LW-1:0] m_last, m_min, m_max;
  logic [63:0]   m_sum;
  logic          m_ovf;

  latency_stats #(.DATA_WIDTH(DW), .LAT_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .lat_thresh(thr),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tuser(i_tuser),
    .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tuser(o_tuser),
    .o_tready(o_tready),
    .pkt_count(pkt_count), .exceed_count(exceed_count),
    .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset_stats();
    m_cnt = '0; m_exc = '0; m_last = '0; m_min = LONES; m_max = '0; m_sum = '0; m_ovf = 1'b0;
  endtask

  task automatic model_sample(input logic [LW-1:0] lat);
    logic [64:0] s;
    logic first;
    first  = (m_cnt == 0);
    m_last = lat;
    if (m_cnt == CMAX) m_ovf = 1'b1; else m_cnt = m_cnt + 1'b1;
    if (lat > thr) begin
      if (m_exc == CMAX) m_ovf = 1'b1; else m_exc = m_exc + 1'b1;
    end
    s = 65'(m_sum) + 65'(lat);
    if (s > 65'(64'hFFFF_FFFF_FFFF_FFFF)) begin m_sum = '1; m_ovf = 1'b1; end
    else m_sum = s[63:0];
    m_min = (first || lat < m_min) ? lat : m_min;
    m_max = (first || lat > m_max) ? lat : m_max;
  endtask

  task automatic check_outputs();
    check("o_tvalid", o_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("o_tdata", o_tdata, exp_q[0].d);
      check("o_tlast", o_tlast, exp_q[0].l);
      check("o_tuser", o_tuser, exp_q[0].u);
    end
    check("pkt_count", pkt_count, m_cnt);
    check("exceed_count", exceed_count, m_exc);
    check("lat_last", lat_last, m_last);
    check("lat_min", lat_min, m_min);
    check("lat_max", lat_max, m_max);
    check("lat_sum", lat_sum, m_sum);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic get_ready(output logic r);
    case (rdy_mode)
      1: r = ($urandom_range(0, 3) != 0);
      2: r = (ready_q.size() != 0) ? ready_q.pop_front() : 1'b1;
      default: r = 1'b1;
    endcase
  endtask

  // One clock: drive at negedge, update the model at posedge, check at next negedge.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic [127:0] u, input logic clr, output logic acc);
    logic r, rdy_exp;
    get_ready(r);
    o_tready = r;
    i_tvalid = v; i_tdata = d; i_tlast = l; i_tuser = u; clear = clr;
    #1;
    rdy_exp = (exp_q.size() == 0) || r;
    check("i_tready", i_tready, rdy_exp);
    acc = v && rdy_exp;
    @(posedge clk);
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (acc) exp_q.push_back('{u: u, l: l, d: d});
    if (clr) model_reset_stats();
    if (acc && m_sop) model_sample(u[LW-1:0]);
    if (acc) m_sop = l;
    @(negedge clk);
    clear = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic clr = 1'b0);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, (i == 0) ? clr : 1'b0, acc);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [127:0] u,
                           input logic clr);
    logic acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      tick(1'b1, d, l, u, (tries == 0) ? clr : 1'b0, acc);
      tries++;
    end
    if (!acc) check("beat_timeout", 0, 1);
  endtask

  task automatic send_pkt(input int n, input logic [LW-1:0] lat, input logic clr,
                          input logic [LW-1:0] body_lat);
    logic [127:0] u;
    for (int b = 0; b < n; b++) begin
      u = {$urandom, $urandom, 64'h0};
      u[63] = (b == n - 1);
      u[LW-1:0] = (b == 0) ? lat : body_lat;
      send_beat($urandom, b == n - 1, u, (b == 0) ? clr : 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_tvalid = 1'b0;
    #1;
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_o_tdata", o_tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_lat_min", lat_min, LONES);
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    m_sop = 1'b1;
    model_reset_stats();
    reset = 1'b0;
  endtask

  initial begin
    model_reset_stats();
    repeat (2) @(negedge clk);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tuser", o_tuser, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_exceed", exceed_count, 0);
    check("rst_max", lat_max, 0);
    check("rst_sum", lat_sum, 0);
    check("rst_ovf", overflow, 0);
    check("rst_min", lat_min, LONES);
    reset = 1'b0;

    // three 4-beat packets
    thr = 200;
    send_pkt(4, 100, 1'b0, 5000);
    send_pkt(4, 40, 1'b0, 5000);
    send_pkt(4, 250, 1'b0, 5000);
    idle(2);
    check("t1_pkt", pkt_count, 3);
    check("t1_min", lat_min, 40);
    check("t1_max", lat_max, 250);
    check("t1_sum", lat_sum, 390);
    check("t1_last", lat_last, 250);
    check("t1_exc", exceed_count, 1);

    // clear alone
    idle(1, 1'b1);
    check("clr_pkt", pkt_count, 0);
    check("clr_min", lat_min, LONES);
    check("clr_sum", lat_sum, 0);

    // single-beat packets
    send_pkt(1, 7, 1'b0, 0);
    send_pkt(1, 7, 1'b0, 0);
    send_pkt(1, 9, 1'b0, 0);
    idle(1);
    check("t2_pkt", pkt_count, 3);
    check("t2_min", lat_min, 7);
    check("t2_max", lat_max, 9);
    check("t2_sum", lat_sum, 23);

    // stalled 6-beat packet with odd body latencies
    rdy_mode = 2;
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_pkt(6, 11, 1'b0, 999);
    idle(2);
    rdy_mode = 0;
    check("t3_pkt", pkt_count, 4);
    check("t3_max", lat_max, 11);
    check("t3_sum", lat_sum, 34);

    // clear coincident with a sample
    send_pkt(2, 55, 1'b1, 999);
    idle(1);
    check("t4_pkt", pkt_count, 1);
    check("t4_min", lat_min, 55);
    check("t4_max", lat_max, 55);
    check("t4_sum", lat_sum, 55);

    // saturation of the counters
    idle(1, 1'b1);
    for (int i = 0; i < 14; i++) send_pkt(1, 300, 1'b0, 0);
    idle(1);
    check("t5_pre", pkt_count, CMAX - 1);
    send_pkt(2, 300, 1'b0, 0);
    send_pkt(1, 300, 1'b0, 0);
    idle(1);
    check("t5_pkt", pkt_count, CMAX);
    check("t5_ovf", overflow, 1);
    idle(3);
    check("t5_ovf_hold", overflow, 1);
    idle(1, 1'b1);
    check("t5_ovf_clr", overflow, 0);

    // reset mid-packet
    send_beat(32'hA1, 1'b0, 128'd77, 1'b0);
    send_beat(32'hA2, 1'b0, 128'd88, 1'b0);
    do_reset();
    send_pkt(2, 12, 1'b0, 999);
    idle(1);
    check("t6_pkt", pkt_count, 1);
    check("t6_last", lat_last, 12);

    // randomized traffic
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      thr = {16'h0, $urandom} >> $urandom_range(0, 31);
      send_pkt($urandom_range(1, 5), {16'h0, $urandom} >> $urandom_range(0, 31),
               ($urandom_range(0, 19) == 0), {$urandom, $urandom});
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3), ($urandom_range(0, 3) == 0));
    end
    rdy_mode = 0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
